mul_32b: RTL

- Sequential signed 32x32 multiply-add: P = A*B + sign-extended C, 64-bit exact result.
- This is the inverse of the signed divider. It rebuilds the dividend as X = Q*Y + R and serves as the datapath's multiplier.
- Its in_valid/out_valid/in_error interface matches the divider, so the two chain directly and a bench can self-check divide-then-multiply.
- Radix-2 Booth, one iteration per clock.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_32b_booth_step.sv | 33 +++
 rtl/mul_32b.sv | 101 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential signed multiply-add and its companion divider bench.
package mul_pkg;

  localparam int N     = 32;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB
  } booth_op_e;

  // Radix-2 Booth recoding of the current multiplier LSB and the previously shifted-out bit.
  function automatic booth_op_e booth_decode(input logic m0, input logic q1);
    case ({m0, q1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mul_32b_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand, then arithmetic shift.
module booth_step
  import mul_pkg::*;
(
  input  logic signed [N:0]   acc,
  input  logic        [N-1:0] mul,
  input  logic                q_1,
  input  logic signed [N-1:0] mcand,
  output logic signed [N:0]   acc_next,
  output logic        [N-1:0] mul_next,
  output logic                q_1_next
);

  logic signed [N:0] mcand_ext;
  logic signed [N:0] sum;
  booth_op_e         op;

  // acc carries one guard bit so that negating the most negative multiplicand stays exact.
  always_comb begin
    mcand_ext = {mcand[N-1], mcand};
    op        = booth_decode(mul[0], q_1);
    sum       = acc;
    case (op)
      OP_ADD:  sum = acc + mcand_ext;
      OP_SUB:  sum = acc - mcand_ext;
      default: sum = acc;
    endcase
    acc_next = {sum[N], sum[N:1]};
    mul_next = {sum[0], mul[N-1:1]};
    q_1_next = mul[0];
  end

endmodule

// File: rtl/mul_32b.sv
// Sequential signed N x N multiply-add, P = A*B + sext(C), one Booth iteration per clock.
module mul_32b
  import mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [N-1:0]   A,
  input  logic signed [N-1:0]   B,
  input  logic signed [N-1:0]   C,
  output logic signed [2*N-1:0] P,
  output logic                  out_valid,
  output logic                  ovf,
  output logic                  busy,
  output logic                  in_error
);

  state_e               state;
  logic signed [N-1:0]  a_r;
  logic signed [N-1:0]  c_r;
  logic signed [N:0]    acc;
  logic        [N-1:0]  mul;
  logic                 q_1;
  logic [CNT_W-1:0]     count;

  logic signed [N:0]    acc_next;
  logic        [N-1:0]  mul_next;
  logic                 q_1_next;
  logic                 accept;
  logic                 reject;
  logic signed [2*N-1:0] sum_fin;

  // True when the upper N+1 bits are pure sign extension, i.e. the value fits in N signed bits.
  function automatic logic fits_n(input logic [N:0] upper);
    return (upper == '0) || (&upper);
  endfunction

  booth_step u_step (
    .acc      (acc),
    .mul      (mul),
    .q_1      (q_1),
    .mcand    (a_r),
    .acc_next (acc_next),
    .mul_next (mul_next),
    .q_1_next (q_1_next)
  );

  assign busy    = (state == CALC) || (state == FIN);
  assign accept  = in_valid && ((state == IDLE) || (state == DONE));
  assign reject  = in_valid && busy;
  assign sum_fin = $signed({acc[N-1:0], mul}) + $signed({{N{c_r[N-1]}}, c_r});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a_r       <= '0;
      c_r       <= '0;
      acc       <= '0;
      mul       <= '0;
      q_1       <= 1'b0;
      count     <= '0;
      P         <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      in_error  <= 1'b0;
    end else begin
      in_error <= reject;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_r       <= A;
            c_r       <= C;
            acc       <= '0;
            mul       <= B;
            q_1       <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mul   <= mul_next;
          q_1   <= q_1_next;
          count <= count + 1'b1;
          if (count == CNT_W'(N - 1)) state <= FIN;
        end
        // Final addend merge; |A*B+C| < 2^(2N-1) so the 2N-bit sum cannot wrap.
        FIN: begin
          P         <= sum_fin;
          ovf       <= !fits_n(sum_fin[2*N-1:N-1]);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
